// File: rtl/axi_mem_responder.sv
// Single-port word memory answering one read or write request at a time after a fixed latency.
// Optional build macro: MEM_OOR_ZERO_EN (drop out-of-range writes, return zero for out-of-range reads).
module axi_mem_responder #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_request_mem,
  input  logic                  write_request_mem,
  input  logic [ADDR_WIDTH-1:0] write_address_mem,
  input  logic [DATA_WIDTH-1:0] write_data_mem,
  output logic [DATA_WIDTH-1:0] read_data_mem,
  output logic                  axi_valid_to_mem,
  output logic                  axi_ready_to_mem,
  output logic [ADDR_WIDTH-1:0] read_address_mem
);

  localparam int unsigned ALSB  = $clog2(DATA_WIDTH / 8);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    rd_q, rd_d;
  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0]   cap_data_q, cap_data_d;
  logic [ADDR_WIDTH-1:0]   cap_addr_q, cap_addr_d;
  logic                    mem_we_c;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [IDX_W-1:0]        idx_c;
  logic [DATA_WIDTH-1:0]   mem_rd_c;
  logic                    wr_allow_c;

  assign idx_c = write_address_mem[ALSB +: IDX_W];

`ifdef MEM_OOR_ZERO_EN
  // Any set bit above the indexed field means the address lies beyond the array.
  logic oor_c;
  assign oor_c      = (write_address_mem >> (ALSB + IDX_W)) != '0;
  assign mem_rd_c   = oor_c ? '0 : mem[idx_c];
  assign wr_allow_c = !oor_c;
`else
  assign mem_rd_c   = mem[idx_c];
  assign wr_allow_c = 1'b1;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    ready_d    = ready_q;
    valid_d    = 1'b0;
    rdata_d    = rdata_q;
    raddr_d    = raddr_q;
    cap_data_d = cap_data_q;
    cap_addr_d = cap_addr_q;
    mem_we_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!ready_q) begin
          ready_d = 1'b1;
        end else if (write_request_mem) begin
          mem_we_c = wr_allow_c;
          cnt_d    = CNT_W'(LATENCY - 1);
          ready_d  = 1'b0;
          rd_d     = 1'b0;
          state_d  = S_WAIT;
        end else if (read_request_mem) begin
          cap_data_d = mem_rd_c;
          cap_addr_d = write_address_mem;
          cnt_d      = CNT_W'(LATENCY - 1);
          ready_d    = 1'b0;
          rd_d       = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rd_q) begin
          valid_d = 1'b1;
          rdata_d = cap_data_q;
          raddr_d = cap_addr_q;
          state_d = S_RESP;
        end else begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      rdata_q    <= '0;
      raddr_q    <= '0;
      cap_data_q <= '0;
      cap_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      rdata_q    <= rdata_d;
      raddr_q    <= raddr_d;
      cap_data_q <= cap_data_d;
      cap_addr_q <= cap_addr_d;
    end
  end

  // Array contents survive reset; a write accepted before reset stays committed.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[idx_c] <= write_data_mem;
  end

  assign read_data_mem    = rdata_q;
  assign axi_valid_to_mem = valid_q;
  assign axi_ready_to_mem = ready_q;
  assign read_address_mem = raddr_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: directed table, hand-written corner sequences and
// randomized transactions checked against a word-array model with latency rules.
module tb_axi_mem_responder;

  localparam int unsigned DW  = 64;
  localparam int unsigned AW  = 32;
  localparam int unsigned DEP = 256;
  localparam int unsigned LAT = 4;
  localparam int unsigned BYTES_SPAN = DEP * (DW / 8);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          read_request_mem = 1'b0;
  logic          write_request_mem = 1'b0;
  logic [AW-1:0] write_address_mem = '0;
  logic [DW-1:0] write_data_mem = '0;
  logic [DW-1:0] read_data_mem;
  logic          axi_valid_to_mem;
  logic          axi_ready_to_mem;
  logic [AW-1:0] read_address_mem;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] model [DEP];

  axi_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .read_request_mem(read_request_mem), .write_request_mem(write_request_mem),
    .write_address_mem(write_address_mem), .write_data_mem(write_data_mem),
    .read_data_mem(read_data_mem), .axi_valid_to_mem(axi_valid_to_mem),
    .axi_ready_to_mem(axi_ready_to_mem), .read_address_mem(read_address_mem)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic int unsigned word_of(input logic [AW-1:0] a);
    return (int'(a) / (DW / 8)) % DEP;
  endfunction

  function automatic bit out_of_range(input logic [AW-1:0] a);
`ifdef MEM_OOR_ZERO_EN
    return a >= BYTES_SPAN;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (out_of_range(a)) return '0;
    return model[word_of(a)];
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!out_of_range(a)) model[word_of(a)] = d;
  endfunction

  // Called at a falling edge; returns at a falling edge with ready observed high.
  task automatic wait_ready();
    int n = 0;
    while (!axi_ready_to_mem && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!axi_ready_to_mem) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within 40 cycles");
    end
  endtask

  // One complete transaction with full latency/handshake checking.
  task automatic txn(input bit is_wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [DW-1:0] exp);
    wait_ready();
    write_request_mem = is_wr;
    read_request_mem  = !is_wr;
    write_address_mem = a;
    write_data_mem    = d;
    @(posedge clk);
    @(negedge clk);
    read_request_mem  = 1'b0;
    write_request_mem = 1'b0;
    write_address_mem = $urandom;
    write_data_mem    = {$urandom, $urandom};
    if (is_wr) model_write(a, d);
    chk("busy_after_accept", DW'(axi_ready_to_mem), DW'(0));
    for (int k = 1; k < int'(LAT); k++) begin
      @(negedge clk);
      chk("wait_ready_low", DW'(axi_ready_to_mem), DW'(0));
      chk("wait_valid_low", DW'(axi_valid_to_mem), DW'(0));
    end
    @(negedge clk);
    if (is_wr) begin
      chk("wr_done_ready", DW'(axi_ready_to_mem), DW'(1));
      chk("wr_no_valid", DW'(axi_valid_to_mem), DW'(0));
    end else begin
      chk("rd_valid", DW'(axi_valid_to_mem), DW'(1));
      chk("rd_ready_low", DW'(axi_ready_to_mem), DW'(0));
      chk("rd_data", read_data_mem, exp);
      chk("rd_addr_echo", DW'(read_address_mem), DW'(a));
      @(negedge clk);
      chk("rd_valid_pulse_end", DW'(axi_valid_to_mem), DW'(0));
      chk("rd_ready_back", DW'(axi_ready_to_mem), DW'(1));
      chk("rd_data_hold", read_data_mem, exp);
    end
  endtask

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            w;

    tbl[0] = '{1'b1, 32'h0000_0040, 64'hDEAD_BEEF_0123_4567, 64'h0};
    tbl[1] = '{1'b0, 32'h0000_0040, 64'h0, 64'hDEAD_BEEF_0123_4567};
    tbl[2] = '{1'b1, 32'h0000_0008, 64'h1111, 64'h0};
    tbl[3] = '{1'b1, 32'h0001_0008, 64'h77, 64'h0};
`ifdef MEM_OOR_ZERO_EN
    tbl[4] = '{1'b0, 32'h0000_0008, 64'h0, 64'h1111};
    tbl[5] = '{1'b0, 32'h0001_0008, 64'h0, 64'h0};
`else
    tbl[4] = '{1'b0, 32'h0000_0008, 64'h0, 64'h77};
    tbl[5] = '{1'b0, 32'h0001_0008, 64'h0, 64'h77};
`endif
    tbl[6] = '{1'b0, 32'h0000_0047, 64'h0, 64'hDEAD_BEEF_0123_4567};

    // Reset values and release
    repeat (3) @(negedge clk);
    chk("rst_ready", DW'(axi_ready_to_mem), DW'(0));
    chk("rst_valid", DW'(axi_valid_to_mem), DW'(0));
    chk("rst_rdata", read_data_mem, DW'(0));
    chk("rst_raddr", DW'(read_address_mem), DW'(0));
    rst = 1'b1;
    #1;
    chk("release_ready_before_edge", DW'(axi_ready_to_mem), DW'(0));
    @(negedge clk);
    chk("release_ready_after_edge", DW'(axi_ready_to_mem), DW'(1));
    chk("release_valid", DW'(axi_valid_to_mem), DW'(0));
    chk("release_rdata", read_data_mem, DW'(0));

    // Fill the array so every model word is known
    for (int i = 0; i < int'(DEP); i++) txn(1'b1, AW'(i * (DW / 8)), {$urandom, $urandom}, '0);

    for (int i = 0; i < 7; i++) txn(tbl[i].is_wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp);

    // Simultaneous requests: the write wins, the held read follows at the next idle
    wait_ready();
    write_request_mem = 1'b1;
    read_request_mem  = 1'b1;
    write_address_mem = 32'h0000_0080;
    write_data_mem    = 64'h5A;
    @(posedge clk);
    @(negedge clk);
    write_request_mem = 1'b0;
    model_write(32'h80, 64'h5A);
    chk("both_ready_low", DW'(axi_ready_to_mem), DW'(0));
    repeat (LAT - 1) @(negedge clk);
    chk("both_no_valid_in_write", DW'(axi_valid_to_mem), DW'(0));
    @(negedge clk);
    chk("both_write_done", DW'(axi_ready_to_mem), DW'(1));
    chk("both_write_no_valid", DW'(axi_valid_to_mem), DW'(0));
    @(posedge clk);
    @(negedge clk);
    read_request_mem = 1'b0;
    chk("both_read_accepted", DW'(axi_ready_to_mem), DW'(0));
    repeat (LAT - 1) @(negedge clk);
    @(negedge clk);
    chk("both_read_valid", DW'(axi_valid_to_mem), DW'(1));
    chk("both_read_data", read_data_mem, 64'h5A);
    chk("both_read_addr", DW'(read_address_mem), DW'(32'h80));
    @(negedge clk);

    // Reset during a pending read discards the response
    wait_ready();
    read_request_mem  = 1'b1;
    write_address_mem = 32'h0000_0040;
    @(posedge clk);
    @(negedge clk);
    read_request_mem = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ready", DW'(axi_ready_to_mem), DW'(0));
    chk("midrst_valid", DW'(axi_valid_to_mem), DW'(0));
    chk("midrst_rdata", read_data_mem, DW'(0));
    chk("midrst_raddr", DW'(read_address_mem), DW'(0));
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < int'(LAT) + 2; k++) begin
      @(negedge clk);
      chk("midrst_no_valid", DW'(axi_valid_to_mem), DW'(0));
    end
    chk("midrst_ready_back", DW'(axi_ready_to_mem), DW'(1));
    txn(1'b0, 32'h0000_0040, '0, model_read(32'h40));

    // Randomized mix, including addresses past the array span
    for (int i = 0; i < 150; i++) begin
      w = 1'($urandom_range(0, 1));
      a = $urandom & 32'h0001_FFFF;
      if ($urandom_range(0, 3) != 0) a = a % BYTES_SPAN;
      d = {$urandom, $urandom};
      if (w) txn(1'b1, a, d, '0);
      else   txn(1'b0, a, '0, model_read(a));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
